// File: rtl/binary_to_onehot_pipeline.sv
// Registered binary-to-one-hot encoder with a valid/ready handshake on each
// side and a two-entry skid buffer (main + skid register).
//
// Each accepted index is encoded once at capture and stored as
// {invalid, onehot}. The main register drives the outputs directly. The skid
// register absorbs one extra entry so that input_ready can be a flop and still
// allow one transfer per cycle.
//
// Ports:
//   clock          rising-edge clock
//   resetn         asynchronous active-low reset
//   input_valid    upstream presents an index
//   input_ready    block can accept an index (registered)
//   input_binary   binary index
//   output_valid   output_onehot / output_invalid are valid
//   output_ready   downstream accepts
//   output_onehot  one-hot encoding of the index (zero when empty)
//   output_invalid index was >= WIDTH_ONEHOT
module binary_to_onehot_pipeline #(
  parameter int unsigned WIDTH_ONEHOT = 8,
  parameter int unsigned WIDTH_BINARY = $clog2(WIDTH_ONEHOT)
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    input_valid,
  output logic                    input_ready,
  input  logic [WIDTH_BINARY-1:0] input_binary,
  output logic                    output_valid,
  input  logic                    output_ready,
  output logic [WIDTH_ONEHOT-1:0] output_onehot,
  output logic                    output_invalid
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  // Entry layout: {invalid, onehot}.
  localparam int unsigned EntryW = WIDTH_ONEHOT + 1;

  state_e            state_q;
  logic [EntryW-1:0] main_q;
  logic [EntryW-1:0] skid_q;
  logic              valid_q;
  logic              ready_q;

  logic [EntryW-1:0] encoded;
  logic              in_xfer;
  logic              out_xfer;

  // An index with no matching bit position is out of range, so invalid is just
  // the NOR of the one-hot vector. WIDTH_ONEHOT <= 2**WIDTH_BINARY, so the
  // truncation of i never aliases.
  function automatic logic [EntryW-1:0] encode(input logic [WIDTH_BINARY-1:0] idx);
    logic [WIDTH_ONEHOT-1:0] oh;
    oh = '0;
    for (int i = 0; i < int'(WIDTH_ONEHOT); i++) begin
      if (idx == WIDTH_BINARY'(i)) begin
        oh[i] = 1'b1;
      end
    end
    return {~|oh, oh};
  endfunction

  assign encoded  = encode(input_binary);
  assign in_xfer  = input_valid & ready_q;
  assign out_xfer = valid_q & output_ready;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        StEmpty: begin
          if (in_xfer) begin
            main_q  <= encoded;
            valid_q <= 1'b1;
            state_q <= StOne;
          end
        end
        StOne: begin
          if (in_xfer && !out_xfer) begin
            skid_q  <= encoded;
            ready_q <= 1'b0;
            state_q <= StTwo;
          end else if (in_xfer && out_xfer) begin
            main_q <= encoded;
          end else if (out_xfer) begin
            // Clear main so the outputs read zero while empty.
            main_q  <= '0;
            valid_q <= 1'b0;
            state_q <= StEmpty;
          end
        end
        StTwo: begin
          if (out_xfer) begin
            main_q  <= skid_q;
            skid_q  <= '0;
            ready_q <= 1'b1;
            state_q <= StOne;
          end
        end
        default: begin
          state_q <= StEmpty;
          main_q  <= '0;
          skid_q  <= '0;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign input_ready    = ready_q;
  assign output_valid   = valid_q;
  assign output_onehot  = main_q[WIDTH_ONEHOT-1:0];
  assign output_invalid = main_q[WIDTH_ONEHOT];

endmodule
